// File: rtl/blit_cmd_arbiter.sv
// blit_cmd_arbiter
//   Collects blitter commands from a supervisor and a user port into two
//   small FIFOs and presents them one at a time to the blitter, alternating
//   between the ports when both have work. User commands carrying a
//   privileged opcode (bit 7 set) are swallowed and counted.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   sup_cmd/valid/ready   : supervisor command push port (128-bit command)
//   usr_cmd/valid/ready   : user command push port (128-bit command)
//   cmd, cmd_valid        : command currently presented to the blitter
//   next_cmd              : blitter consumed the presented command (pulse)
//   blit_idle             : blitter pipeline is empty
//   priv_error            : pulse, one user command was rejected
//   priv_err_count        : saturating count of rejected user commands
//   busy                  : anything queued, presented or still in the blitter

// Simple FIFO of 128-bit entries; DEPTH must be a power of two >= 2.
module blit_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [127:0] i_data,
  input  logic         i_pop,
  output logic [127:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   C_FULL    = (AW + 1)'(DEPTH);

  logic [127:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_wr <= r_wr + C_PTR_ONE;
      end
      if (i_pop) begin
        r_rd <= r_rd + C_PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_cnt == C_FULL);
  assign o_empty = (r_cnt == '0);
endmodule

module blit_cmd_arbiter #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] sup_cmd,
  input  logic         sup_valid,
  output logic         sup_ready,
  input  logic [127:0] usr_cmd,
  input  logic         usr_valid,
  output logic         usr_ready,
  output logic [127:0] cmd,
  output logic         cmd_valid,
  input  logic         next_cmd,
  input  logic         blit_idle,
  output logic         priv_error,
  output logic [7:0]   priv_err_count,
  output logic         busy
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_cmd;
  logic         r_cmd_valid;
  logic         r_last_usr;
  logic         r_priv_error;
  logic [7:0]   r_priv_cnt;

  logic [127:0] w_sup_head;
  logic [127:0] w_usr_head;
  logic         w_sup_full;
  logic         w_usr_full;
  logic         w_sup_empty;
  logic         w_usr_empty;
  logic         w_sup_push;
  logic         w_usr_accept;
  logic         w_usr_push;
  logic         w_reject;
  logic         w_pop_sup;
  logic         w_pop_usr;
  logic         w_grant_usr;

  // Ready depends only on the occupancy at the start of the cycle, so a pop
  // in the same cycle can never make room for a push.
  assign sup_ready    = !w_sup_full;
  assign usr_ready    = !w_usr_full;
  assign w_sup_push   = sup_valid && sup_ready;
  assign w_usr_accept = usr_valid && usr_ready;
  // Privileged user opcodes complete the handshake but are dropped.
  assign w_usr_push   = w_usr_accept && !usr_cmd[7];
  assign w_reject     = w_usr_accept && usr_cmd[7];

  blit_cmd_fifo #(.DEPTH(QUEUE_DEPTH)) u_sup_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_sup_push),
    .i_data  (sup_cmd),
    .i_pop   (w_pop_sup),
    .o_head  (w_sup_head),
    .o_full  (w_sup_full),
    .o_empty (w_sup_empty)
  );

  blit_cmd_fifo #(.DEPTH(QUEUE_DEPTH)) u_usr_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_usr_push),
    .i_data  (usr_cmd),
    .i_pop   (w_pop_usr),
    .o_head  (w_usr_head),
    .o_full  (w_usr_full),
    .o_empty (w_usr_empty)
  );

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop_sup   = 1'b0;
    w_pop_usr   = 1'b0;
    w_grant_usr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_sup_empty || !w_usr_empty) begin
          // User wins when it is alone, or on a tie when supervisor went last.
          w_grant_usr = !w_usr_empty && (w_sup_empty || !r_last_usr);
          w_pop_usr   = w_grant_usr;
          w_pop_sup   = !w_grant_usr;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (next_cmd) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Presented command, valid flag and round-robin memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cmd       <= 128'd0;
      r_cmd_valid <= 1'b0;
      r_last_usr  <= 1'b1;
    end else if (w_pop_sup || w_pop_usr) begin
      r_cmd       <= w_grant_usr ? w_usr_head : w_sup_head;
      r_cmd_valid <= 1'b1;
      r_last_usr  <= w_grant_usr;
    end else if ((r_state == ST_PRESENT) && next_cmd) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Rejection pulse and saturating counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_priv_error <= 1'b0;
      r_priv_cnt   <= 8'd0;
    end else begin
      r_priv_error <= w_reject;
      if (w_reject && (r_priv_cnt != 8'hFF)) begin
        r_priv_cnt <= r_priv_cnt + 8'd1;
      end
    end
  end

  assign cmd            = r_cmd;
  assign cmd_valid      = r_cmd_valid;
  assign priv_error     = r_priv_error;
  assign priv_err_count = r_priv_cnt;
  assign busy           = !w_sup_empty || !w_usr_empty ||
                          (r_state != ST_IDLE) || !blit_idle;
endmodule

// File: tb/tb_blit_cmd_arbiter.sv
// Scoreboard bench for blit_cmd_arbiter: stimulus pushes the command it
// expects the arbiter to issue into exp_q; a monitor pops and compares on
// every new presentation and checks the command stays stable while valid.
module tb_blit_cmd_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] sup_cmd = 128'd0;
  logic         sup_valid = 1'b0;
  logic         sup_ready;
  logic [127:0] usr_cmd = 128'd0;
  logic         usr_valid = 1'b0;
  logic         usr_ready;
  logic [127:0] cmd;
  logic         cmd_valid;
  logic         next_cmd = 1'b0;
  logic         blit_idle = 1'b1;
  logic         priv_error;
  logic [7:0]   priv_err_count;
  logic         busy;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [127:0] exp_q[$];
  int           rise_q[$];
  logic         mon_prev = 1'b0;
  logic [127:0] mon_held = 128'd0;
  logic [127:0] mon_exp;
  logic [127:0] fill [5];

  localparam logic [127:0] C_S81 = 128'h0000_0004_0000_0003_0000_0002_0000_0081;
  localparam logic [127:0] C_S0  = 128'h5000_0003_5000_0002_5000_0001_0000_0010;
  localparam logic [127:0] C_S1  = 128'h5100_0003_5100_0002_5100_0001_0000_0011;
  localparam logic [127:0] C_U0  = 128'h7000_0003_7000_0002_7000_0001_0000_0020;
  localparam logic [127:0] C_U1  = 128'h7100_0003_7100_0002_7100_0001_0000_0021;
  localparam logic [127:0] C_U82 = 128'hDEAD_0003_DEAD_0002_DEAD_0001_0000_0082;
  localparam logic [127:0] C_U01 = 128'h1234_0003_1234_0002_1234_0001_0000_0001;
  localparam logic [127:0] C_UFF = 128'hBAD0_0003_BAD0_0002_BAD0_0001_0000_00FF;
  localparam logic [127:0] C_BAD = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0066;
  localparam logic [127:0] C_C40 = 128'h4040_0003_4040_0002_4040_0001_0000_0040;

  blit_cmd_arbiter #(.QUEUE_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .sup_cmd        (sup_cmd),
    .sup_valid      (sup_valid),
    .sup_ready      (sup_ready),
    .usr_cmd        (usr_cmd),
    .usr_valid      (usr_valid),
    .usr_ready      (usr_ready),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .next_cmd       (next_cmd),
    .blit_idle      (blit_idle),
    .priv_error     (priv_error),
    .priv_err_count (priv_err_count),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sup_valid = 1'b0;
    usr_valid = 1'b0;
    next_cmd = 1'b0;
    blit_idle = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rise_q.delete();
  endtask

  // Monitor: every new presentation must match the next expected command.
  always @(negedge clock) begin
    if (reset) begin
      mon_prev = 1'b0;
    end else begin
      if (cmd_valid && !mon_prev) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %0h, expected no command", cmd);
        end else begin
          mon_exp = exp_q.pop_front();
          check("issue", cmd, mon_exp);
        end
        mon_held = cmd;
      end else if (cmd_valid && mon_prev) begin
        check("hold_stable", cmd, mon_held);
      end
      mon_prev = cmd_valid;
    end
  end

  initial begin
    fill[0] = 128'hF0; fill[1] = 128'hF1; fill[2] = 128'hF2;
    fill[3] = 128'hF3; fill[4] = 128'hF4;

    // Reset state and single supervisor command with opcode 0x81.
    do_reset();
    check("rst_cmd_valid", 128'(cmd_valid), 128'd0);
    check("rst_cmd", cmd, 128'd0);
    check("rst_priv_error", 128'(priv_error), 128'd0);
    check("rst_priv_count", 128'(priv_err_count), 128'd0);
    check("rst_sup_ready", 128'(sup_ready), 128'd1);
    check("rst_usr_ready", 128'(usr_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    sup_cmd = C_S81; sup_valid = 1'b1; exp_q.push_back(C_S81);
    tick(); sup_valid = 1'b0;
    check("s81_not_yet", 128'(cmd_valid), 128'd0);
    tick();
    check("s81_valid", 128'(cmd_valid), 128'd1);
    check("s81_busy", 128'(busy), 128'd1);
    tick(); tick();
    check("s81_still_valid", 128'(cmd_valid), 128'd1);
    next_cmd = 1'b1;
    tick(); next_cmd = 1'b0;
    check("s81_fall", 128'(cmd_valid), 128'd0);
    tick();
    check("s81_gap_low", 128'(cmd_valid), 128'd0);
    check("s81_retained", cmd, C_S81);
    check("s81_idle_busy", 128'(busy), 128'd0);

    // Round robin with two commands per port, immediate acknowledge.
    do_reset();
    sup_cmd = C_S0; sup_valid = 1'b1; usr_cmd = C_U0; usr_valid = 1'b1;
    exp_q.push_back(C_S0); exp_q.push_back(C_U0);
    exp_q.push_back(C_S1); exp_q.push_back(C_U1);
    tick();
    sup_cmd = C_S1; usr_cmd = C_U1;
    tick();
    sup_valid = 1'b0; usr_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      next_cmd = cmd_valid;
      tick();
    end
    next_cmd = 1'b0;
    check("rr_drained", 128'(exp_q.size()), 128'd0);
    check("rr_issue_count", 128'(rise_q.size()), 128'd4);
    if (rise_q.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        check("rr_spacing", 128'(rise_q[i+1] - rise_q[i]), 128'd3);
      end
    end

    // Privileged user opcode rejected, then a normal one issued.
    do_reset();
    usr_cmd = C_U82; usr_valid = 1'b1;
    tick();
    check("priv_pulse", 128'(priv_error), 128'd1);
    check("priv_count1", 128'(priv_err_count), 128'd1);
    usr_cmd = C_U01; exp_q.push_back(C_U01);
    tick(); usr_valid = 1'b0;
    check("priv_pulse_end", 128'(priv_error), 128'd0);
    check("priv_count_hold", 128'(priv_err_count), 128'd1);
    tick();
    check("u01_valid", 128'(cmd_valid), 128'd1);
    next_cmd = 1'b1;
    tick(); next_cmd = 1'b0;
    repeat (4) tick();
    check("priv_drained", 128'(exp_q.size()), 128'd0);
    usr_cmd = C_UFF; usr_valid = 1'b1;
    repeat (300) tick();
    usr_valid = 1'b0;
    tick(); tick();
    check("priv_saturate", 128'(priv_err_count), 128'd255);
    check("priv_none_issued", 128'(cmd_valid), 128'd0);

    // Supervisor queue fills: one presented plus four queued.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sup_cmd = fill[k]; sup_valid = 1'b1; exp_q.push_back(fill[k]);
      if (k == 4) check("full_ready_before", 128'(sup_ready), 128'd1);
      tick();
    end
    check("full_ready_low", 128'(sup_ready), 128'd0);
    check("full_presented", 128'(cmd_valid), 128'd1);
    sup_cmd = C_BAD; sup_valid = 1'b1;
    next_cmd = 1'b1;
    tick(); next_cmd = 1'b0;
    check("full_ready_gap", 128'(sup_ready), 128'd0);
    tick();
    check("full_ready_idle", 128'(sup_ready), 128'd0);
    tick(); sup_valid = 1'b0;
    check("full_ready_back", 128'(sup_ready), 128'd1);
    for (int i = 0; i < 20; i++) begin
      next_cmd = cmd_valid;
      tick();
    end
    next_cmd = 1'b0;
    check("full_drained", 128'(exp_q.size()), 128'd0);

    // Reset while presenting with both queues loaded.
    do_reset();
    sup_cmd = C_S0; sup_valid = 1'b1; usr_cmd = C_U0; usr_valid = 1'b1;
    exp_q.push_back(C_S0);
    tick();
    sup_cmd = C_S1; usr_cmd = C_U1;
    tick(); sup_valid = 1'b0; usr_valid = 1'b0;
    check("mid_presenting", 128'(cmd_valid), 128'd1);
    tick();
    reset = 1'b1; blit_idle = 1'b0;
    tick();
    check("mid_valid", 128'(cmd_valid), 128'd0);
    check("mid_busy", 128'(busy), 128'd1);
    check("mid_sup_ready", 128'(sup_ready), 128'd1);
    check("mid_usr_ready", 128'(usr_ready), 128'd1);
    check("mid_cmd", cmd, 128'd0);
    blit_idle = 1'b1;
    tick();
    check("mid_busy_idle", 128'(busy), 128'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("mid_no_issue", 128'(cmd_valid), 128'd0);

    // Stray next_cmd while nothing presented is ignored.
    do_reset();
    next_cmd = 1'b1;
    tick(); next_cmd = 1'b0;
    sup_cmd = C_C40; sup_valid = 1'b1; exp_q.push_back(C_C40);
    tick(); sup_valid = 1'b0;
    tick();
    check("stray_valid", 128'(cmd_valid), 128'd1);
    repeat (3) tick();
    check("stray_held", 128'(cmd_valid), 128'd1);
    next_cmd = 1'b1;
    tick(); next_cmd = 1'b0;
    check("stray_consumed", 128'(cmd_valid), 128'd0);
    tick();

    check("final_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
